uart_wb_host: RTL and testbench

- Wishbone classic initiator that drives the UART register slave's bus: i_we, i_stb, i_addr, i_data in; o_ack, o_data out.
- Converts a valid/ready command stream from a host-side controller or test harness into single Wishbone transactions.
- Returns the result on a valid/ready response stream.
- Adds an ack timeout and a sticky protocol-error flag so a hung or misbehaving slave cannot stall the host.

---
 rtl/uart_wb_pkg.sv | 13 +
 rtl/uart_wb_host_if.sv | 32 +++
 rtl/wb_ack_timer.sv | 27 ++
 rtl/uart_wb_host.sv | 115 +++++++++++
 tb/tb_uart_wb_host.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types and register addresses for the UART Wishbone host and its callers.
package uart_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic ADDR_TX = 1'b0;
    localparam logic ADDR_RX = 1'b1;

endpackage

// File: rtl/uart_wb_host_if.sv
// Command/response streams plus the Wishbone classic bus seen by the UART host.
interface uart_wb_host_if #(
    parameter int G_WORD_WIDTH = 4
);
    logic                    i_cmd_valid;
    logic                    o_cmd_ready;
    logic                    i_cmd_we;
    logic                    i_cmd_addr;
    logic [G_WORD_WIDTH-1:0] i_cmd_data;
    logic                    o_rsp_valid;
    logic                    i_rsp_ready;
    logic [G_WORD_WIDTH-1:0] o_rsp_data;
    logic                    o_rsp_err;
    logic                    o_wb_stb;
    logic                    o_wb_we;
    logic                    o_wb_addr;
    logic [G_WORD_WIDTH-1:0] o_wb_data;
    logic                    i_wb_ack;
    logic [G_WORD_WIDTH-1:0] i_wb_data;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready, i_wb_ack, i_wb_data,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
        output o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready, i_wb_ack, i_wb_data,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
        input  o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );
endinterface

// File: rtl/wb_ack_timer.sv
// Counts strobe cycles while enabled; expired flags the last allowed cycle.
module wb_ack_timer #(
    parameter int G_TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = (G_TIMEOUT > 0) ? W'(G_TIMEOUT - 1) : '0;

    logic [W-1:0] cnt;

    // A zero timeout pins the count at 0 and never expires.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt <= '0;
        end else if (i_en && !o_expired && (G_TIMEOUT != 0)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign o_expired = (G_TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/uart_wb_host.sv
// Wishbone classic initiator: one command in, one bus transaction, one response out,
// with an ack timeout and a sticky flag for acks that arrive without a strobe.
module uart_wb_host
    import uart_wb_pkg::*;
#(
    parameter int G_WORD_WIDTH = 4,
    parameter int G_TIMEOUT    = 256,
    parameter int G_CNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    uart_wb_host_if.master         bus,
    output logic                   o_proto_err,
    output logic [G_CNT_WIDTH-1:0] o_txn_cnt
);
    state_t                  state_q, state_d;
    logic                    cmd_ready_d, rsp_valid_d, rsp_err_d;
    logic                    wb_stb_d, wb_we_d, wb_addr_d, proto_err_d;
    logic [G_WORD_WIDTH-1:0] rsp_data_d, wb_data_d;
    logic [G_CNT_WIDTH-1:0]  txn_cnt_d;
    logic                    timer_clear, timer_expired;

    wb_ack_timer #(.G_TIMEOUT(G_TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (timer_clear),
        .i_en      (state_q == BUS),
        .o_expired (timer_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            bus.o_cmd_ready <= 1'b1;
            bus.o_rsp_valid <= 1'b0;
            bus.o_rsp_data  <= '0;
            bus.o_rsp_err   <= 1'b0;
            bus.o_wb_stb    <= 1'b0;
            bus.o_wb_we     <= 1'b0;
            bus.o_wb_addr   <= 1'b0;
            bus.o_wb_data   <= '0;
            o_proto_err     <= 1'b0;
            o_txn_cnt       <= '0;
        end else begin
            state_q         <= state_d;
            bus.o_cmd_ready <= cmd_ready_d;
            bus.o_rsp_valid <= rsp_valid_d;
            bus.o_rsp_data  <= rsp_data_d;
            bus.o_rsp_err   <= rsp_err_d;
            bus.o_wb_stb    <= wb_stb_d;
            bus.o_wb_we     <= wb_we_d;
            bus.o_wb_addr   <= wb_addr_d;
            bus.o_wb_data   <= wb_data_d;
            o_proto_err     <= proto_err_d;
            o_txn_cnt       <= txn_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = bus.o_cmd_ready;
        rsp_valid_d = bus.o_rsp_valid;
        rsp_data_d  = bus.o_rsp_data;
        rsp_err_d   = bus.o_rsp_err;
        wb_stb_d    = bus.o_wb_stb;
        wb_we_d     = bus.o_wb_we;
        wb_addr_d   = bus.o_wb_addr;
        wb_data_d   = bus.o_wb_data;
        txn_cnt_d   = o_txn_cnt;
        timer_clear = 1'b0;
        // Any ack outside a strobe is a slave fault; it only raises the flag.
        proto_err_d = o_proto_err | (bus.i_wb_ack & ~bus.o_wb_stb);

        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid && bus.o_cmd_ready) begin
                    wb_we_d     = bus.i_cmd_we;
                    wb_addr_d   = bus.i_cmd_addr;
                    wb_data_d   = bus.i_cmd_data;
                    wb_stb_d    = 1'b1;
                    cmd_ready_d = 1'b0;
                    timer_clear = 1'b1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // Ack is tested first so it beats a timeout in the same cycle.
                if (bus.i_wb_ack) begin
                    rsp_data_d  = bus.o_wb_we ? '0 : bus.i_wb_data;
                    rsp_err_d   = 1'b0;
                    wb_stb_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    txn_cnt_d   = o_txn_cnt + G_CNT_WIDTH'(1);
                    state_d     = RSP;
                end else if (timer_expired) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    wb_stb_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    txn_cnt_d   = o_txn_cnt + G_CNT_WIDTH'(1);
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_wb_host.sv
// Scoreboard bench for uart_wb_host: directed commands against a programmable ack-delay slave.
module tb_uart_wb_host;
    import uart_wb_pkg::*;

    localparam int W  = 4;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          proto_err;
    logic [CW-1:0] txn_cnt;

    uart_wb_host_if #(.G_WORD_WIDTH(W)) bif ();

    uart_wb_host #(.G_WORD_WIDTH(W), .G_TIMEOUT(TO), .G_CNT_WIDTH(CW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .bus         (bif),
        .o_proto_err (proto_err),
        .o_txn_cnt   (txn_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic         we;
        logic         addr;
        logic [W-1:0] data;
        int           stb_len;
    } bus_exp_t;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           lat;
    } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int           slave_delay = 0;
    logic [W-1:0] slave_rdata = '0;
    logic         inj_ack = 1'b0;
    int           scnt = 0;

    bit m_in_stb = 0;
    int m_stb_cnt = 0;
    bit m_prev_v = 0;
    int m_acc_cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: acks during the slave_delay-th strobe cycle; 0 means it never acks.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (bif.o_wb_stb) scnt++;
            else scnt = 0;
            if (bif.o_wb_stb && slave_delay != 0 && scnt == slave_delay) begin
                bif.i_wb_ack  = 1'b1;
                bif.i_wb_data = slave_rdata;
            end else begin
                bif.i_wb_ack  = inj_ack;
                bif.i_wb_data = 4'hE;
            end
        end
    end

    // Monitor: compares bus activity and responses against the queued expectations.
    initial begin
        forever begin
            @(negedge i_clk);
            if (bif.i_cmd_valid && bif.o_cmd_ready) m_acc_cyc = cyc;
            if (bif.o_wb_stb) begin
                if (!m_in_stb) begin
                    m_in_stb  = 1;
                    m_stb_cnt = 0;
                end
                m_stb_cnt++;
                chk("stb_expected", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) begin
                    chk("wb_we", bif.o_wb_we, exp_bus[0].we);
                    chk("wb_addr", bif.o_wb_addr, exp_bus[0].addr);
                    chk("wb_data", bif.o_wb_data, exp_bus[0].data);
                end
            end else if (m_in_stb) begin
                m_in_stb = 0;
                chk("stb_end_expected", exp_bus.size() != 0, 1);
                if (exp_bus.size() != 0) begin
                    chk("stb_len", m_stb_cnt, exp_bus[0].stb_len);
                    void'(exp_bus.pop_front());
                end
            end
            if (bif.o_rsp_valid && !m_prev_v) begin
                chk("rsp_expected", exp_rsp.size() != 0, 1);
                if (exp_rsp.size() != 0) chk("rsp_latency", cyc - m_acc_cyc, exp_rsp[0].lat);
            end
            if (bif.o_rsp_valid && bif.i_rsp_ready && exp_rsp.size() != 0) begin
                chk("rsp_data", bif.o_rsp_data, exp_rsp[0].data);
                chk("rsp_err", bif.o_rsp_err, exp_rsp[0].err);
                void'(exp_rsp.pop_front());
            end
            m_prev_v = bif.o_rsp_valid;
        end
    end

    task automatic issue(input logic we, input logic addr, input logic [W-1:0] data,
                         input int delay, input logic [W-1:0] rdata, input int stb_len,
                         input bit has_rsp, input logic [W-1:0] exp_data, input logic exp_err);
        bus_exp_t b;
        rsp_exp_t r;
        bit done = 0;
        slave_delay = delay;
        slave_rdata = rdata;
        b.we = we;
        b.addr = addr;
        b.data = data;
        b.stb_len = stb_len;
        exp_bus.push_back(b);
        if (has_rsp) begin
            r.data = exp_data;
            r.err  = exp_err;
            r.lat  = stb_len + 1;
            exp_rsp.push_back(r);
        end
        @(posedge i_clk);
        #1;
        bif.i_cmd_we    = we;
        bif.i_cmd_addr  = addr;
        bif.i_cmd_data  = data;
        bif.i_cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge i_clk);
            if (bif.o_cmd_ready) done = 1;
        end
        chk("cmd_accepted", done, 1);
        @(posedge i_clk);
        #1;
        bif.i_cmd_valid = 1'b0;
        bif.i_cmd_data  = '0;
    endtask

    task automatic wait_done(input int exp_cnt);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge i_clk);
            if (exp_bus.size() == 0 && exp_rsp.size() == 0 && bif.o_cmd_ready) ok = 1;
        end
        chk("txn_done", ok, 1);
        chk("txn_cnt", txn_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bif.i_cmd_valid = 1'b0;
        bif.i_cmd_we    = 1'b0;
        bif.i_cmd_addr  = 1'b0;
        bif.i_cmd_data  = '0;
        bif.i_rsp_ready = 1'b1;
        bif.i_wb_ack    = 1'b0;
        bif.i_wb_data   = '0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_cmd_ready", bif.o_cmd_ready, 1);
        chk("rst_rsp_valid", bif.o_rsp_valid, 0);
        chk("rst_rsp_data", bif.o_rsp_data, 0);
        chk("rst_rsp_err", bif.o_rsp_err, 0);
        chk("rst_wb_stb", bif.o_wb_stb, 0);
        chk("rst_wb_we", bif.o_wb_we, 0);
        chk("rst_wb_data", bif.o_wb_data, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_txn_cnt", txn_cnt, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Write 0xA to TX, registered-ack slave.
        issue(1'b1, ADDR_TX, 4'hA, 2, 4'h7, 2, 1, 4'h0, 1'b0);
        wait_done(1);

        // Read RX returning 0x5 while the response is back-pressured.
        bif.i_rsp_ready = 1'b0;
        issue(1'b0, ADDR_RX, 4'h0, 2, 4'h5, 2, 1, 4'h5, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            if (bif.o_rsp_valid) seen = 1;
        end
        chk("hold_rsp_seen", seen, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("hold_rsp_valid", bif.o_rsp_valid, 1);
            chk("hold_rsp_data", bif.o_rsp_data, 4'h5);
            chk("hold_cmd_ready", bif.o_cmd_ready, 0);
        end
        @(posedge i_clk);
        #1;
        bif.i_rsp_ready = 1'b1;
        @(negedge i_clk);
        chk("hs_cmd_ready_low", bif.o_cmd_ready, 0);
        @(negedge i_clk);
        chk("post_hs_cmd_ready", bif.o_cmd_ready, 1);
        chk("post_hs_rsp_valid", bif.o_rsp_valid, 0);
        wait_done(2);

        // Silent slave: times out after TO strobe cycles.
        issue(1'b0, ADDR_RX, 4'h0, 0, 4'hF, TO, 1, 4'h0, 1'b1);
        wait_done(3);

        // Next command completes normally with a combinational-style ack.
        issue(1'b1, ADDR_RX, 4'h3, 1, 4'h9, 1, 1, 4'h0, 1'b0);
        wait_done(4);

        // Ack on the last allowed strobe cycle beats the timeout.
        issue(1'b0, ADDR_TX, 4'h0, TO, 4'h9, TO, 1, 4'h9, 1'b0);
        wait_done(5);
        chk("proto_err_clean", proto_err, 0);

        // Stray ack while idle.
        @(negedge i_clk);
        inj_ack = 1'b1;
        @(negedge i_clk);
        inj_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("proto_err_set", proto_err, 1);
        chk("proto_no_rsp", bif.o_rsp_valid, 0);
        chk("proto_txn_cnt", txn_cnt, 5);
        repeat (5) @(negedge i_clk);
        chk("proto_err_sticky", proto_err, 1);

        issue(1'b0, ADDR_RX, 4'h0, 3, 4'hC, 3, 1, 4'hC, 1'b0);
        wait_done(6);
        chk("proto_err_still", proto_err, 1);

        // Reset while the strobe is up.
        issue(1'b1, ADDR_TX, 4'h4, 0, 4'h0, 4, 0, 4'h0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_stb", bif.o_wb_stb, 0);
        chk("mid_rst_rsp_valid", bif.o_rsp_valid, 0);
        chk("mid_rst_cmd_ready", bif.o_cmd_ready, 1);
        chk("mid_rst_txn_cnt", txn_cnt, 0);
        chk("mid_rst_proto_err", proto_err, 0);
        wait_done(0);

        // Fresh write after reset.
        issue(1'b1, ADDR_TX, 4'h6, 2, 4'h1, 2, 1, 4'h0, 1'b0);
        wait_done(1);
        chk("final_proto_err", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
